// File: rtl/rx_hash.sv
// rx_hash: receive-side classifier for a 256-bit AXI-Stream ingress path.
// Parses destination IP/port from the second beat of each packet, computes a
// 32-bit Toeplitz hash with a 320-bit key, classifies the packet, and queues
// one result per packet for release on `load`. Ingress beats are forwarded
// with one cycle of latency.
module rx_hash #(
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic [319:0]          hash_key,
  input  logic                  load,
  output logic [31:0]           m_axis_hash,
  output logic [3:0]            m_axis_hash_type,
  output logic                  m_axis_hash_valid,
  output logic [31:0]           m_axis_dest_ip,
  output logic [15:0]           m_axis_dest_port,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [KEEP_WIDTH-1:0] data_keep,
  output logic                  data_valid,
  output logic                  data_last,
  output logic                  clk_out,
  output logic                  rst_out
);

  localparam logic [63:0] SIGNATURE = 64'h89504E470D0A1A0A;

  typedef struct packed {
    logic [31:0] hash;
    logic [3:0]  htype;
    logic [31:0] ip;
    logic [15:0] port;
  } result_t;

  logic [1:0]  beat_cnt_q, beat_cnt_d;
  logic [31:0] cap_ip_q, cap_ip_d;
  logic [15:0] cap_port_q, cap_port_d;
  logic        cap_sig_q, cap_sig_d;

  logic [31:0] hash_val;
  result_t     push_entry;
  logic        push, pop;

  result_t     fifo_mem [4];
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]  count_q;

  result_t     out_q;
  logic        out_valid_q;

  logic [DATA_WIDTH-1:0] data_q;
  logic [KEEP_WIDTH-1:0] keep_q;
  logic                  valid_q, last_q;

  // Key bits below 241 never fall inside a 32-bit window for a 48-bit input.
  logic unused_key;
  assign unused_key = ^hash_key[240:0];

  // Beat counter and capture registers: clear on beat 0, capture on beat 1.
  // The _d values already include this beat, so they double as the bypass
  // path when tlast arrives on beat 0 or beat 1.
  always_comb begin
    // NOTE: every combinationally written signal gets a default first, so no path can infer a latch.
    beat_cnt_d = beat_cnt_q;
    cap_ip_d   = cap_ip_q;
    cap_port_d = cap_port_q;
    cap_sig_d  = cap_sig_q;
    if (s_axis_tvalid) begin
      if (s_axis_tlast)              beat_cnt_d = 2'd0;
      else if (beat_cnt_q != 2'd3)   beat_cnt_d = beat_cnt_q + 2'd1;
      if (beat_cnt_q == 2'd0) begin
        cap_ip_d   = '0;
        cap_port_d = '0;
        cap_sig_d  = 1'b0;
      end else if (beat_cnt_q == 2'd1) begin
        cap_ip_d   = s_axis_tdata[223:192];
        cap_port_d = s_axis_tdata[239:224];
        cap_sig_d  = (s_axis_tdata[79:16] == SIGNATURE);
      end
    end
  end

  // Toeplitz hash over {ip, port}, MSB first, using the live key.
  always_comb begin
    logic [47:0] hash_in;
    hash_in  = {cap_ip_d, cap_port_d};
    hash_val = '0;
    for (int i = 0; i < 48; i++) begin
      if (hash_in[47-i]) hash_val = hash_val ^ hash_key[319-i -: 32];
    end
  end

  // Result entry and queue handshakes; a push into a full queue is dropped.
  always_comb begin
    push_entry.hash  = hash_val;
    push_entry.htype = {1'b0, (cap_port_d == 16'h0015),
                        (cap_port_d == 16'h0016), cap_sig_d};
    push_entry.ip    = cap_ip_d;
    push_entry.port  = cap_port_d;
    push = s_axis_tvalid && s_axis_tlast && (count_q != 3'd4);
    pop  = load && (count_q != 3'd0);
  end

  // Queue storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the pointers and count define validity, so stale contents are never read.
    if (push) fifo_mem[wr_ptr_q] <= push_entry;
  end

  // Control state, popped result and one-cycle forwarding stage.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      beat_cnt_q  <= '0;
      cap_ip_q    <= '0;
      cap_port_q  <= '0;
      cap_sig_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      keep_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      cap_ip_q    <= cap_ip_d;
      cap_port_q  <= cap_port_d;
      cap_sig_q   <= cap_sig_d;
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
      out_valid_q <= pop;
      if (pop) out_q <= fifo_mem[rd_ptr_q];
      data_q      <= s_axis_tdata;
      keep_q      <= s_axis_tkeep;
      valid_q     <= s_axis_tvalid;
      last_q      <= s_axis_tlast;
    end
  end

  assign m_axis_hash       = out_q.hash;
  assign m_axis_hash_type  = out_q.htype;
  assign m_axis_dest_ip    = out_q.ip;
  assign m_axis_dest_port  = out_q.port;
  assign m_axis_hash_valid = out_valid_q;
  assign data_out          = data_q;
  assign data_keep         = keep_q;
  assign data_valid        = valid_q;
  assign data_last         = last_q;
  assign clk_out           = clk;
  assign rst_out           = rst;

endmodule

// File: tb/tb_rx_hash.sv
// tb_rx_hash: randomized scoreboard bench for rx_hash. A packet-level model
// derives each result from the packet's second beat; a 4-deep model queue
// feeds expected pops into a scoreboard that a negedge monitor drains.
module tb_rx_hash;

  localparam int DW = 256;
  localparam int KW = DW / 8;
  localparam logic [63:0] SIG = 64'h89504E470D0A1A0A;
  localparam logic [255:0] PKT_A =
    256'haaaa0016_bbbbbbbb_bbbbbbbb_bbbbbbbb_bbbbbbbb_bbbb89504E47_0D0A1A0A_bbbb;
  localparam logic [255:0] PKT_B =
    256'haaaa0015_bbbbbbbb_bbbbbbbb_bbbbbbbb_bbbbbbbb_bbbb89504E47_0D0A1A0A_bbbb;
  localparam logic [255:0] PKT_C = {32{8'hEE}};

  typedef struct packed {
    logic [31:0] hash;
    logic [3:0]  htype;
    logic [31:0] ip;
    logic [15:0] port;
  } res_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic          s_axis_tvalid, s_axis_tlast;
  logic [319:0]  hash_key;
  logic          load;
  logic [31:0]   m_axis_hash;
  logic [3:0]    m_axis_hash_type;
  logic          m_axis_hash_valid;
  logic [31:0]   m_axis_dest_ip;
  logic [15:0]   m_axis_dest_port;
  logic [DW-1:0] data_out;
  logic [KW-1:0] data_keep;
  logic          data_valid, data_last, clk_out, rst_out;

  rx_hash #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .hash_key(hash_key), .load(load),
    .m_axis_hash(m_axis_hash), .m_axis_hash_type(m_axis_hash_type),
    .m_axis_hash_valid(m_axis_hash_valid), .m_axis_dest_ip(m_axis_dest_ip),
    .m_axis_dest_port(m_axis_dest_port),
    .data_out(data_out), .data_keep(data_keep), .data_valid(data_valid),
    .data_last(data_last), .clk_out(clk_out), .rst_out(rst_out)
  );

  always #5 clk = ~clk;

  res_t          model_q[$];
  res_t          sb[$];
  res_t          held;
  logic [255:0]  pkt_beats[$];
  logic [DW-1:0] exp_data;
  logic [KW-1:0] exp_keep;
  logic          exp_valid, exp_last;
  int            vectors = 0;
  int            miscompares = 0;
  bit            mon_en = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [319:0] rnd_key();
    logic [319:0] k;
    for (int i = 0; i < 10; i++) k[i*32 +: 32] = $urandom();
    return k;
  endfunction

  // Reference Toeplitz: slide a 32-bit window down the key one bit per input bit.
  function automatic logic [31:0] toeplitz_ref(input logic [47:0] din, input logic [319:0] key);
    logic [31:0]  h;
    logic [319:0] sh;
    h = '0;
    for (int i = 0; i < 48; i++) begin
      if (din[47-i]) begin
        sh = key >> (288 - i);
        h  = h ^ sh[31:0];
      end
    end
    return h;
  endfunction

  // Packet-level result: fields come from the second beat if there was one.
  function automatic res_t classify(input logic [255:0] b1, input bit has_b1, input logic [319:0] key);
    res_t r;
    r = '0;
    if (has_b1) begin
      r.port     = b1[239:224];
      r.ip       = b1[223:192];
      r.htype[0] = (b1[79:16] == SIG);
      r.htype[1] = (r.port == 16'h0016);
      r.htype[2] = (r.port == 16'h0015);
    end
    r.hash = toeplitz_ref({r.ip, r.port}, key);
    return r;
  endfunction

  // Apply one cycle of inputs, let the edge happen, then advance the model.
  task automatic drive(input logic v, input logic [255:0] d, input logic l, input logic ld);
    int   pre;
    res_t r;
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tkeep  = $urandom();
    load          = ld;
    @(posedge clk);
    exp_data  = rst ? '0 : s_axis_tdata;
    exp_keep  = rst ? '0 : s_axis_tkeep;
    exp_valid = rst ? 1'b0 : s_axis_tvalid;
    exp_last  = rst ? 1'b0 : s_axis_tlast;
    if (rst) begin
      pkt_beats.delete();
      model_q.delete();
      sb.delete();
      held = '0;
    end else begin
      pre = model_q.size();
      if (load && pre > 0) sb.push_back(model_q.pop_front());
      if (s_axis_tvalid) begin
        pkt_beats.push_back(s_axis_tdata);
        if (s_axis_tlast) begin
          r = classify(pkt_beats.size() >= 2 ? pkt_beats[1] : '0,
                       pkt_beats.size() >= 2, hash_key);
          if (pre < 4) model_q.push_back(r);
          pkt_beats.delete();
        end
      end
    end
    #1;
  endtask

  task automatic idle(input logic ld);
    drive(1'b0, rnd256(), 1'($urandom_range(1)), ld);
  endtask

  // chaos: random idle gaps, random loads and occasional key changes mid-packet.
  task automatic send_pkt(input logic [255:0] b1, input int n, input bit chaos);
    for (int i = 0; i < n; i++) begin
      if (chaos) begin
        while ($urandom_range(3) == 0) idle(1'($urandom_range(2) == 0));
        if ($urandom_range(7) == 0) hash_key = rnd_key();
      end
      drive(1'b1, (i == 1) ? b1 : rnd256(), i == n - 1,
            chaos ? 1'($urandom_range(2) == 0) : 1'b0);
    end
  endtask

  function automatic logic [255:0] rnd_b1();
    logic [255:0] v;
    v = rnd256();
    if ($urandom_range(1) == 1) v[79:16] = SIG;
    case ($urandom_range(3))
      0:       v[239:224] = 16'h0015;
      1:       v[239:224] = 16'h0016;
      default: v[239:224] = v[239:224];
    endcase
    return v;
  endfunction

  // Monitor: a pulse is due exactly when the scoreboard holds an entry.
  always @(negedge clk) begin
    if (mon_en) begin
      check("hash_valid", m_axis_hash_valid, sb.size() != 0);
      if (sb.size() != 0) held = sb.pop_front();
      check("hash", m_axis_hash, held.hash);
      check("hash_type", m_axis_hash_type, held.htype);
      check("dest_ip", m_axis_dest_ip, held.ip);
      check("dest_port", m_axis_dest_port, held.port);
      check("data_out", data_out, exp_data);
      check("data_keep", data_keep, exp_keep);
      check("data_valid", data_valid, exp_valid);
      check("data_last", data_last, exp_last);
      check("clk_out", clk_out, clk);
      check("rst_out", rst_out, rst);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    hash_key = rnd_key();
    held = '0;
    idle(1'b0);
    idle(1'b1);
    mon_en = 1'b1;
    check("reset_valid", m_axis_hash_valid, 1'b0);
    check("reset_hash", m_axis_hash, 32'h0);
    check("reset_data_valid", data_valid, 1'b0);
    rst = 1'b0;

    // Directed packets A, B, C with a load two cycles after tlast.
    send_pkt(PKT_A, 4, 1'b0); idle(1'b0); idle(1'b1); idle(1'b0); idle(1'b0);
    send_pkt(PKT_B, 4, 1'b0); idle(1'b0); idle(1'b1); idle(1'b0); idle(1'b0);
    send_pkt(PKT_C, 4, 1'b0); idle(1'b0); idle(1'b1); idle(1'b0); idle(1'b0);

    // Five back-to-back packets overflow the 4-entry queue; drain with load held.
    for (int k = 0; k < 5; k++) send_pkt(rnd_b1(), 2 + (k % 3), 1'b0);
    for (int k = 0; k < 6; k++) idle(1'b1);
    idle(1'b0); idle(1'b0);

    // Single-beat packet, then a load on an empty queue.
    send_pkt(rnd_b1(), 1, 1'b0); idle(1'b0); idle(1'b1); idle(1'b0);
    idle(1'b1); idle(1'b0); idle(1'b0);

    // Reset mid-packet with a result already queued; the queue must be flushed.
    send_pkt(PKT_C, 2, 1'b0);
    drive(1'b1, rnd256(), 1'b0, 1'b0);
    drive(1'b1, PKT_B, 1'b0, 1'b0);
    rst = 1'b1;
    drive(1'b1, rnd256(), 1'b1, 1'b0);
    rst = 1'b0;
    check("rst_mid_valid", m_axis_hash_valid, 1'b0);
    check("rst_mid_ip", m_axis_dest_ip, 32'h0);
    check("rst_mid_data_out", data_out, 256'h0);
    idle(1'b1); idle(1'b0);
    send_pkt(PKT_A, 3, 1'b0); idle(1'b1); idle(1'b0); idle(1'b0);

    // Randomized traffic with concurrent loads and key changes.
    for (int k = 0; k < 60; k++) send_pkt(rnd_b1(), $urandom_range(1, 6), 1'b1);
    for (int k = 0; k < 8; k++) idle(1'b1);
    idle(1'b0); idle(1'b0);
    check("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rx_hash.md
Name: rx_hash

Overview:
- Receive-side classification block on a 256-bit AXI-Stream ingress path.
- Extracts the destination IP and destination port from fixed positions in the second beat of each packet.
- Computes a 32-bit Toeplitz hash over them with a 320-bit key and classifies the packet into a 4-bit type.
- Queues one result per packet for release on `load`; ingress data is also forwarded to the next stage with one cycle of latency.

Parameters:
- DATA_WIDTH, 256, stream data width in bits; parsing offsets assume 256.
- KEEP_WIDTH, DATA_WIDTH/8, stream byte-enable width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_axis_tdata  in  DATA_WIDTH  ingress data; byte 0 is at bits [7:0].
- s_axis_tkeep  in  KEEP_WIDTH  ingress byte enables; forwarded only, not used for parsing.
- s_axis_tvalid  in  1  beat valid; there is no tready, the block is always ready.
- s_axis_tlast  in  1  last beat of packet.
- hash_key  in  320  Toeplitz key; bit 319 is the first key bit.
- load  in  1  pop strobe for the result queue.
- m_axis_hash  out  32  Toeplitz hash of the popped result.
- m_axis_hash_type  out  4  classification of the popped result.
- m_axis_hash_valid  out  1  one-cycle pulse when a result is presented.
- m_axis_dest_ip  out  32  destination IP of the popped result.
- m_axis_dest_port  out  16  destination port of the popped result.
- data_out  out  DATA_WIDTH  registered s_axis_tdata.
- data_keep  out  KEEP_WIDTH  registered s_axis_tkeep.
- data_valid  out  1  registered s_axis_tvalid.
- data_last  out  1  registered s_axis_tlast.
- clk_out  out  1  combinational copy of clk.
- rst_out  out  1  combinational copy of rst.

Behaviour:
- Clocking: single clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: all registered outputs 0; beat counter 0; capture registers 0; queue empty.
- Beat accounting:
  - A beat is accepted on any rising edge with s_axis_tvalid=1; beats with tvalid=0 are ignored.
  - The beat counter increments per accepted beat, saturates at 3, and returns to 0 after an accepted beat with tlast=1.
- Capture on beat index 1:
  - dest_port = tdata[239:224]
  - dest_ip = tdata[223:192]
  - sig = (tdata[79:16] == 64'h89504E470D0A1A0A)
- Capture registers are cleared at the start of each packet. A packet ending before beat 1 therefore yields ip=0, port=0, sig=0, hash=0x00000000.
- Hash type:
  - bit0 = sig
  - bit1 = (dest_port == 16'h0016)
  - bit2 = (dest_port == 16'h0015)
  - bit3 = 0 (reserved)
- Hash: Toeplitz over the 48-bit input {dest_ip, dest_port}, processed MSB first. Start at 0; for input bit i (i=0 is the MSB), if the bit is 1, XOR in hash_key[319-i -: 32].
  - The hash may be computed combinationally from the capture registers; key changes mid-packet take effect.
- Result queue:
  - 4-entry FIFO of {hash, type, ip, port}.
  - Push on the rising edge accepting a tlast beat, using the capture values. When the tlast beat is itself beat 1, use the values captured in that same beat (bypass).
  - Push while full: the new result is dropped and contents are unchanged.
- Pop:
  - load=1 at a rising edge with the queue non-empty: the oldest entry is driven onto the m_axis_* fields and m_axis_hash_valid=1 for exactly that following cycle.
  - load with the queue empty: valid=0 and fields are held.
  - Fields hold their last popped value while valid=0.
  - Load held high pops one entry per cycle.
  - Simultaneous push and pop: both occur; the pop returns the oldest entry. When the queue is empty, the pushed entry is not popped in the same cycle.
- Forwarding: data_out, data_keep, data_valid and data_last equal the s_axis inputs delayed one clock, unconditionally.
- Reset mid-packet: the packet in progress is discarded, the queue is flushed, and the next accepted beat is beat 0.

Test Plan:
- Packet A, 4 beats:
  - Stimulus: beat1 = 256'haaaa0016 followed by 36 'b' nibbles, then 89504E470D0A1A0A, then bbbb; tlast on beat 3; load pulse 2 cycles later.
  - Required: one valid pulse with port=0x0016, ip=0xBBBBBBBB, type=4'b0011, hash = reference Toeplitz of 48'hBBBBBBBB0016.
- Packet B, same layout with port 0x0015:
  - Required: port=0x0015, ip=0xBBBBBBBB, type=4'b0101.
- Packet C:
  - Stimulus: beat1 = all 0xEE.
  - Required: port=0xEEEE, ip=0xEEEEEEEE, type=4'b0000.
- Five back-to-back packets, no load, then load held 6 cycles:
  - Required: exactly 4 valid pulses, in order, carrying the first four packets' results; the fifth is dropped.
- Single-beat packet (tlast on beat 0), then load:
  - Required: valid pulse with hash=0, type=0, ip=0, port=0.
  - Also: load with the queue empty gives no pulse.
- Forwarding and reset:
  - Required: data_* equal the s_axis inputs one cycle later.
  - Assert rst mid-packet B: all outputs 0, queue empty, and the next packet parses correctly from beat 0.
